// File: rtl/axil_mem_master_if.sv
// rtl/axil_mem_master_if.sv - request/response channel plus AXI4-Lite master bus for axil_mem_master
interface axil_mem_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_wstrb;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] m_axil_awaddr;
  logic [2:0]            m_axil_awprot;
  logic                  m_axil_awvalid;
  logic                  m_axil_awready;
  logic [DATA_WIDTH-1:0] m_axil_wdata;
  logic [STRB_WIDTH-1:0] m_axil_wstrb;
  logic                  m_axil_wvalid;
  logic                  m_axil_wready;
  logic [1:0]            m_axil_bresp;
  logic                  m_axil_bvalid;
  logic                  m_axil_bready;
  logic [ADDR_WIDTH-1:0] m_axil_araddr;
  logic [2:0]            m_axil_arprot;
  logic                  m_axil_arvalid;
  logic                  m_axil_arready;
  logic [DATA_WIDTH-1:0] m_axil_rdata;
  logic [1:0]            m_axil_rresp;
  logic                  m_axil_rvalid;
  logic                  m_axil_rready;

  // master: the bridge itself; slave: requester plus AXI4-Lite target
  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid, input m_axil_awready,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, input m_axil_wready,
    input  m_axil_bresp, m_axil_bvalid, output m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid, input m_axil_arready,
    input  m_axil_rdata, m_axil_rresp, m_axil_rvalid, output m_axil_rready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid, output m_axil_awready,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, output m_axil_wready,
    output m_axil_bresp, m_axil_bvalid, input m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, output m_axil_arready,
    output m_axil_rdata, m_axil_rresp, m_axil_rvalid, input m_axil_rready
  );
endinterface

// File: rtl/axil_mem_master.sv
// rtl/axil_mem_master.sv - single-outstanding request-to-AXI4-Lite master bridge
module axil_mem_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  axil_mem_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    WRITE_RESP = 3'd2,
    READ_ADDR  = 3'd3,
    READ_DATA  = 3'd4,
    RESP       = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  req_ready;
  logic                  awvalid;
  logic                  wvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  rready;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  // Only bit 1 of a response code distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic unused_resp_lsbs;
  assign unused_resp_lsbs = bus.m_axil_bresp[0] ^ bus.m_axil_rresp[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && bus.req_valid) begin
            req_ready <= 1'b0;
            addr_q    <= bus.req_addr;
            wdata_q   <= bus.req_wdata;
            wstrb_q   <= bus.req_wstrb;
            if (bus.req_we) begin
              state   <= WRITE;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= READ_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        WRITE: begin
          // A channel whose valid is already low has completed its handshake.
          if (awvalid && bus.m_axil_awready) awvalid <= 1'b0;
          if (wvalid && bus.m_axil_wready) wvalid <= 1'b0;
          if ((!awvalid || bus.m_axil_awready) && (!wvalid || bus.m_axil_wready)) begin
            state  <= WRITE_RESP;
            bready <= 1'b1;
          end
        end
        WRITE_RESP: begin
          if (bus.m_axil_bvalid) begin
            state      <= RESP;
            bready     <= 1'b0;
            resp_err   <= bus.m_axil_bresp[1];
            resp_rdata <= '0;
            resp_valid <= 1'b1;
          end
        end
        READ_ADDR: begin
          if (bus.m_axil_arready) begin
            state   <= READ_DATA;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        READ_DATA: begin
          if (bus.m_axil_rvalid) begin
            state      <= RESP;
            rready     <= 1'b0;
            resp_err   <= bus.m_axil_rresp[1];
            resp_rdata <= bus.m_axil_rdata;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.resp_valid     = resp_valid;
  assign bus.resp_rdata     = resp_rdata;
  assign bus.resp_err       = resp_err;

  assign bus.m_axil_awaddr  = addr_q;
  assign bus.m_axil_awprot  = 3'b000;
  assign bus.m_axil_awvalid = awvalid;
  assign bus.m_axil_wdata   = wdata_q;
  assign bus.m_axil_wstrb   = wstrb_q;
  assign bus.m_axil_wvalid  = wvalid;
  assign bus.m_axil_bready  = bready;
  assign bus.m_axil_araddr  = addr_q;
  assign bus.m_axil_arprot  = 3'b000;
  assign bus.m_axil_arvalid = arvalid;
  assign bus.m_axil_rready  = rready;
endmodule
